load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles in REQ+WAIT before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cs  input  1  active-low memory-access request from decoder.
REQ-005 load_store  input  1  1 = load, 0 = store.
REQ-006 load_ops  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW.
REQ-007 store_ops  input  3  000 SB, 001 SH, 010 SW.
REQ-008 addr  input  32  effective byte address (ALU result).
REQ-009 wdata  input  32  store data (rs2).
REQ-010 stall  output  1  holds PC/instruction while access in flight.
REQ-011 rdata  output  32  extended load result; valid only with rdata_valid.
REQ-012 rdata_valid  output  1  one-cycle pulse on load completion.
REQ-013 bus_err  output  1  one-cycle pulse on timeout abort.
REQ-014 mem_req, mem_we  output  1 each  bus request / write strobe.
REQ-015 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  input  1 each  request accepted / read data or write ack; mem_rdata  input  32.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: cs==0 with valid op -> latch load_store, op, addr, wdata; go REQ; invalid op (load_ops 101-111, store_ops 011-111) -> no access, stay IDLE.
REQ-020 stall = (IDLE & cs==0 & valid op) | REQ | WAIT, combinational; low in DONE.
REQ-021 REQ: mem_req=1, mem_addr/mem_be/mem_we/mem_wdata stable from latched values until mem_gnt; gnt -> WAIT.
REQ-022 WAIT: mem_req=0; mem_rvalid -> DONE, capturing mem_rdata.
REQ-023 DONE: one cycle; rdata_valid=1 for loads; cs ignored; -> IDLE.
REQ-024 Zero-wait bus (gnt in REQ cycle, rvalid first WAIT cycle): stall high exactly 3 cycles.
REQ-025 Store lanes: SB be=4'b0001<<addr[1:0], data={4{wdata[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}; SW be=4'b1111.
REQ-026 Loads: always mem_be=4'b1111; select byte lane by addr[1:0], halfword by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 Timeout counter SHALL clear on IDLE->REQ, count each REQ/WAIT cycle; on reaching TIMEOUT_CYCLES -> DONE with bus_err=1, rdata=0, rdata_valid=0, mem_req dropped.
REQ-028 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.

Reset
REQ-029 reset low, at any time incl. mid-REQ/WAIT: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, rdata_valid=0, bus_err=0, counter=0, stall driven only by REQ-020.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL not issue a bus access, SHALL pulse output misaligned for one cycle in IDLE, and SHALL not assert stall.
REQ-031 Macro undefined: no misaligned port; misaligned accesses proceed with low address bits truncated per REQ-025/026.

Structure
REQ-032 Package lsu_pkg SHALL hold the FSM state enum and load_ops/store_ops encoding localparams.
REQ-033 Combinational lane steering and extension SHALL live in sub-module lsu_align.

Verification
REQ-034 SW addr 0x100, wdata 0xDEADBEEF, zero-wait bus -> mem_addr 0x100, mem_be 1111, mem_we 1, stall 3 cycles.
REQ-035 LB addr 0x203, mem_rdata 0x80FF0000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x102, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD.
REQ-037 mem_gnt delayed 5 cycles -> mem_req and mem_addr held stable 6 cycles; stall held throughout.
REQ-038 TIMEOUT_CYCLES=8, no mem_rvalid -> bus_err pulse, stall drops, no rdata_valid; reset asserted mid-WAIT -> IDLE, mem_req 0 immediately.
REQ-039 LW addr 0x102: with LSU_MISALIGN_TRAP_EN -> misaligned pulse, no mem_req; without -> mem_addr 0x100 access completes.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   * lsu_state_t      : access FSM states (IDLE, REQ, WAIT, DONE)
//   * LD_* / SO_*      : load_ops / store_ops encodings
//   * op_valid()       : is the decoder's op encoding a supported access
//   * op_misaligned()  : would the access straddle its natural alignment
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  localparam logic [2:0] SO_SB  = 3'b000;
  localparam logic [2:0] SO_SH  = 3'b001;
  localparam logic [2:0] SO_SW  = 3'b010;

  function automatic logic op_valid(input logic is_load, input logic [2:0] op);
    if (is_load) return (op <= LD_LW);
    else         return (op <= SO_SW);
  endfunction

  function automatic logic op_misaligned(input logic is_load, input logic [2:0] op,
                                         input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = is_load ? (op == LD_LH || op == LD_LHU) : (op == SO_SH);
    word = is_load ? (op == LD_LW) : (op == SO_SW);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering for the load/store unit.
// Ports:
//   is_load, op, addr_lo : latched access kind, op encoding, byte offset
//   wdata                : raw store data (rs2)
//   rdata_raw            : word returned by the bus
//   be                   : byte enables (all ones for loads)
//   wdata_lane           : store data replicated across the lanes (0 for loads)
//   rdata_ext            : selected byte/halfword/word, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_raw[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo];
  assign half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata_lane = 32'h0;
    if (!is_load) begin
      case (op)
        SO_SB: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        SO_SH: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          be         = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  always_comb begin
    rdata_ext = rdata_raw;
    case (op)
      LD_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  rdata_ext = {24'h0, byte_sel};
      LD_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  rdata_ext = {16'h0, half_sel};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store engine between the core
// decoder and a request/grant/rvalid memory bus.
// Parameter: TIMEOUT_CYCLES -- cycles allowed in REQ+WAIT before aborting.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses with a one-cycle 'misaligned' pulse instead of
// truncating the low address bits.
// Ports:
//   clk, reset (async, active low)
//   cs (active low), load_store, load_ops, store_ops, addr, wdata : request
//   stall, rdata, rdata_valid, bus_err [, misaligned]             : core side
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata                   : bus out
//   mem_gnt, mem_rvalid, mem_rdata                                 : bus in
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        load_store,
  input  logic [2:0]  load_ops,
  input  logic [2:0]  store_ops,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state_reg, state_next;
  logic        is_load_reg;
  logic [2:0]  op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [CW-1:0] count_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic [2:0]  cur_op;
  logic        req_ok;
  logic        trap;
  logic        start;
  logic        timeout;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

  assign cur_op = load_store ? load_ops : store_ops;
  assign req_ok = !cs && op_valid(load_store, cur_op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap       = op_misaligned(load_store, cur_op, addr[1:0]);
  assign misaligned = (state_reg == S_IDLE) && req_ok && trap;
`else
  assign trap       = 1'b0;
`endif

  assign start   = (state_reg == S_IDLE) && req_ok && !trap;
  // Reaching the last permitted REQ/WAIT cycle aborts even if the bus
  // responds in that same cycle, so the bound is strict.
  assign timeout = (count_reg >= CW'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .is_load    (is_load_reg),
    .op         (op_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .rdata_raw  (mem_rdata),
    .be         (be_lane),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      is_load_reg <= 1'b0;
      op_reg      <= 3'b000;
      addr_reg    <= 32'h0;
      wdata_reg   <= 32'h0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            is_load_reg <= load_store;
            op_reg      <= cur_op;
            addr_reg    <= addr;
            wdata_reg   <= wdata;
            count_reg   <= '0;
            err_reg     <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          count_reg <= count_reg + CW'(1);
          if (timeout) begin
            err_reg   <= 1'b1;
            rdata_reg <= 32'h0;
          end else if (state_reg == S_WAIT && mem_rvalid && is_load_reg) begin
            rdata_reg <= rdata_ext;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_be      = 4'b0000;
    mem_wdata   = 32'h0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        stall = start;
        if (start) state_next = S_REQ;
      end
      S_REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = !is_load_reg;
        mem_addr  = {addr_reg[31:2], 2'b00};
        mem_be    = be_lane;
        mem_wdata = wdata_lane;
        if (timeout)      state_next = S_DONE;
        else if (mem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (timeout || mem_rvalid) state_next = S_DONE;
      end
      S_DONE: begin
        rdata_valid = is_load_reg && !err_reg;
        bus_err     = err_reg;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed scoreboard bench for load_store_unit.
// Stimulus pushes expected bus transfers and completions into queues; a
// monitor pops and compares them as the DUT presents them. A small bus
// responder supplies grant/rvalid with configurable grant latency.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b1;
  logic        load_store = 1'b0;
  logic [2:0]  load_ops = 3'b000;
  logic [2:0]  store_ops = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, rdata_valid, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        exp_mis = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .load_store  (load_store),
    .load_ops    (load_ops),
    .store_ops   (store_ops),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .bus_err     (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned  (misaligned),
`endif
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          req_cycles;
  } bus_t;

  typedef struct {
    int          stall_cycles;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
  } cpl_t;

  bus_t bus_q[$];
  cpl_t cpl_q[$];

  int          checks = 0;
  int          passed = 0;
  int          gnt_dly = 0;
  logic        rv_en = 1'b1;
  logic [31:0] rsp_data = 32'h0;
  logic        quiet = 1'b0;
  logic        stim_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    int   rc;
    logic pend;
    rc   = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid = pend && rv_en;
      mem_rdata  = pend ? rsp_data : 32'h0;
      pend       = 1'b0;
      if (mem_req && reset) begin
        if (rc == gnt_dly) begin
          mem_gnt = 1'b1;
          pend    = 1'b1;
          rc      = 0;
        end else begin
          mem_gnt = 1'b0;
          rc++;
        end
      end else begin
        mem_gnt = 1'b0;
        rc      = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int   cyc;
    int   stall_cnt;
    int   req_cnt;
    int   txn;
    logic prev_stall;
    bus_t b;
    cpl_t c;
    cyc = 0; stall_cnt = 0; req_cnt = 0; txn = 0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (cyc > 5000) begin
        checks++;
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        break;
      end
      if (stim_done) begin
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
        break;
      end
      if (!reset) begin
        chk("rst_ctrl", 32'({mem_req, mem_we, rdata_valid, bus_err, stall, mem_be}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        // An access cut short by reset never completes on the bus.
        if (req_cnt > 0 && bus_q.size() > 0) void'(bus_q.pop_front());
        stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0;
        continue;
      end
      if (quiet) chk("quiet_no_access", 32'({stall, mem_req}), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      if (quiet) chk("misaligned", 32'(misaligned), 32'(exp_mis));
      else if (misaligned) chk("stray_misaligned", 32'd1, 32'd0);
`endif
      if (mem_req) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          b = bus_q[0];
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_be", 32'(mem_be), 32'(b.be));
          chk("mem_we", 32'(mem_we), 32'(b.we));
          chk("mem_wdata", mem_wdata, b.wdata);
          req_cnt++;
          if (mem_gnt) begin
            chk("req_cycles", 32'(req_cnt), 32'(b.req_cycles));
            void'(bus_q.pop_front());
            req_cnt = 0;
          end
        end
      end
      if (stall) stall_cnt++;
      if (prev_stall && !stall) begin
        if (cpl_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          c = cpl_q.pop_front();
          txn++;
          chk("stall_cycles", 32'(stall_cnt), 32'(c.stall_cycles));
          chk("rdata_valid", 32'(rdata_valid), 32'(c.rv));
          chk("bus_err", 32'(bus_err), 32'(c.err));
          if (c.rv || c.err) chk("rdata", rdata, c.rdata);
          $display("txn %0d: stall=%0d rdata_valid=%0b bus_err=%0b rdata=0x%08h",
                   txn, stall_cnt, rdata_valid, bus_err, rdata);
        end
        stall_cnt = 0;
      end else if (rdata_valid || bus_err) begin
        chk("stray_done_pulse", 32'({rdata_valid, bus_err}), 32'd0);
      end
      prev_stall = stall;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic expect_bus(input logic [31:0] ea, input logic [3:0] ebe, input logic ewe,
                            input logic [31:0] ewd, input int rc);
    bus_t b;
    b.addr = ea; b.be = ebe; b.we = ewe; b.wdata = ewd; b.req_cycles = rc;
    bus_q.push_back(b);
  endtask

  task automatic expect_cpl(input int sc, input logic rv, input logic er, input logic [31:0] rd);
    cpl_t c;
    c.stall_cycles = sc; c.rv = rv; c.err = er; c.rdata = rd;
    cpl_q.push_back(c);
  endtask

  task automatic issue(input logic ls, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    cs = 1'b0; load_store = ls; addr = a; wdata = wd;
    load_ops  = ls ? op : 3'b111;
    store_ops = ls ? 3'b111 : op;
    @(posedge clk); #1;
    cs = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // SW zero-wait
    expect_bus(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 1); expect_cpl(3, 1'b0, 1'b0, 32'h0);
    issue(1'b0, SO_SW, 32'h100, 32'hDEADBEEF); wait_idle();
    // LB / LBU byte 3, sign vs zero extension
    rsp_data = 32'h80FF0000;
    expect_bus(32'h200, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'hFFFFFF80);
    issue(1'b1, LD_LB, 32'h203, 32'h0); wait_idle();
    expect_bus(32'h200, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'h00000080);
    issue(1'b1, LD_LBU, 32'h203, 32'h0); wait_idle();
    // SH upper half, SB lane 1
    expect_bus(32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 1); expect_cpl(3, 1'b0, 1'b0, 32'h0);
    issue(1'b0, SO_SH, 32'h102, 32'h0000ABCD); wait_idle();
    expect_bus(32'h100, 4'b0010, 1'b1, 32'h77777777, 1); expect_cpl(3, 1'b0, 1'b0, 32'h0);
    issue(1'b0, SO_SB, 32'h101, 32'h12345677); wait_idle();
    // LH upper half (negative), LHU/LH lower half, LW
    expect_bus(32'h200, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'hFFFF80FF);
    issue(1'b1, LD_LH, 32'h202, 32'h0); wait_idle();
    rsp_data = 32'h1234F00D;
    expect_bus(32'h200, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'h0000F00D);
    issue(1'b1, LD_LHU, 32'h200, 32'h0); wait_idle();
    expect_bus(32'h200, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'hFFFFF00D);
    issue(1'b1, LD_LH, 32'h200, 32'h0); wait_idle();
    rsp_data = 32'hCAFEF00D;
    expect_bus(32'h300, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'hCAFEF00D);
    issue(1'b1, LD_LW, 32'h300, 32'h0); wait_idle();

    // grant delayed 5 cycles: request held 6 cycles, stall 1+6+1
    gnt_dly = 5;
    expect_bus(32'h40, 4'b1111, 1'b1, 32'h01020304, 6); expect_cpl(8, 1'b0, 1'b0, 32'h0);
    issue(1'b0, SO_SW, 32'h40, 32'h01020304); wait_idle();
    gnt_dly = 0;

    // invalid op encodings: no access, no stall
    @(posedge clk); #1;
    quiet = 1'b1; cs = 1'b0; load_store = 1'b1; load_ops = 3'b101;
    @(posedge clk); #1;
    load_store = 1'b0; store_ops = 3'b011;
    @(posedge clk); #1;
    cs = 1'b1;
    @(posedge clk); #1;
    quiet = 1'b0;

    // timeout: granted, never answered -> 8 cycles in REQ+WAIT then bus_err
    rv_en = 1'b0;
    expect_bus(32'h500, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(9, 1'b0, 1'b1, 32'h0);
    issue(1'b1, LD_LW, 32'h500, 32'h0); wait_idle();

    // reset asserted mid-WAIT
    expect_bus(32'h600, 4'b1111, 1'b0, 32'h0, 1);
    issue(1'b1, LD_LW, 32'h600, 32'h0);
    @(posedge clk); #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset asserted mid-REQ: mem_req must drop without waiting for a clock
    gnt_dly = 5;
    expect_bus(32'h700, 4'b1111, 1'b0, 32'h0, 6);
    issue(1'b1, LD_LW, 32'h700, 32'h0);
    @(posedge clk); #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    gnt_dly = 0; rv_en = 1'b1;

    // misaligned LW at 0x102
`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    quiet = 1'b1; exp_mis = 1'b1;
    cs = 1'b0; load_store = 1'b1; load_ops = LD_LW; addr = 32'h102;
    @(posedge clk); #1;
    cs = 1'b1; exp_mis = 1'b0;
    @(posedge clk); #1;
    quiet = 1'b0;
`else
    rsp_data = 32'h11223344;
    expect_bus(32'h100, 4'b1111, 1'b0, 32'h0, 1); expect_cpl(3, 1'b1, 1'b0, 32'h11223344);
    issue(1'b1, LD_LW, 32'h102, 32'h0); wait_idle();
`endif

    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

endmodule
